// File: rtl/vote_resolver_if.sv
`default_nettype none
// ============================================================================
// Module : vote_resolver_if
// Brief  : Result valid/ready channel from vote_resolver to the output stage.
// Rev    : 1.0  initial release
// ============================================================================
interface vote_resolver_if #(
    parameter int FIFO_WIDTH = 16,
    parameter int LABEL_W    = 2
);
    logic                  res_vld;
    logic                  res_rdy;
    logic                  res_is_clf;
    logic [LABEL_W-1:0]    res_label;
    logic [FIFO_WIDTH-1:0] res_value;
    logic                  res_tie;

    modport master (
        output res_vld,
        output res_is_clf,
        output res_label,
        output res_value,
        output res_tie,
        input  res_rdy
    );

    modport slave (
        input  res_vld,
        input  res_is_clf,
        input  res_label,
        input  res_value,
        input  res_tie,
        output res_rdy
    );
endinterface
`default_nettype wire

// File: rtl/vote_resolver.sv
`default_nettype none
// ============================================================================
// Module : vote_resolver
// Brief  : Drains one accumulator result set per inference (argmax over the
//          label FIFOs, or the regression sum) onto a valid/ready port.
//          Define VOTE_RESOLVER_RGS_EN to build the regression path.
// Rev    : 1.0  initial release
// ============================================================================
module vote_resolver #(
    parameter int FIFO_WIDTH = 16,
    parameter int N_LABELS   = 4
) (
    input  wire                           clk,
    input  wire                           rst,
    input  wire                           i_is_clf,
    input  wire                           i_flush,
    output logic [N_LABELS-1:0]           o_clf_fifo_pop,
    input  wire  [N_LABELS*FIFO_WIDTH-1:0] i_clf_fifo_front,
    input  wire  [N_LABELS-1:0]           i_clf_fifo_vld,
    input  wire  [N_LABELS-1:0]           i_clf_fifo_is_empty,
    output logic                          o_rgs_fifo_pop,
    input  wire  [FIFO_WIDTH-1:0]         i_rgs_fifo_front,
    input  wire                           i_rgs_fifo_vld,
    input  wire                           i_rgs_fifo_is_empty,
    vote_resolver_if.master               res_if,
    output logic                          o_busy
);
    localparam int LABEL_W = (N_LABELS > 1) ? $clog2(N_LABELS) : 1;

    localparam logic [2:0] c_S_IDLE    = 3'd0;
    localparam logic [2:0] c_S_POP     = 3'd1;
    localparam logic [2:0] c_S_CAPTURE = 3'd2;
    localparam logic [2:0] c_S_SCAN    = 3'd3;
    localparam logic [2:0] c_S_OUT     = 3'd4;

    localparam logic [LABEL_W-1:0] c_LAST_LANE = LABEL_W'(N_LABELS - 1);

    logic [2:0]            r_state;
    logic [2:0]            w_next_state;
    logic                  r_mode;
    logic [N_LABELS-1:0]   r_mask;
    logic [FIFO_WIDTH-1:0] r_lane [N_LABELS];
    logic [FIFO_WIDTH-1:0] r_best;
    logic [LABEL_W-1:0]    r_label;
    logic [LABEL_W-1:0]    r_idx;
    logic                  r_tie;

    logic [FIFO_WIDTH-1:0] w_front [N_LABELS];
    logic [N_LABELS-1:0]   w_mask_next;
    logic                  w_clf_done;
    logic [FIFO_WIDTH-1:0] w_lane0;
    logic                  w_is_clf;
    logic                  w_rgs_start;
    logic                  w_rgs_vld;
    logic [FIFO_WIDTH-1:0] w_rgs_front;
    logic                  c_RGS_EN;

`ifdef VOTE_RESOLVER_RGS_EN
    assign c_RGS_EN    = 1'b1;
    assign w_is_clf    = i_is_clf;
    assign w_rgs_start = ~i_rgs_fifo_is_empty;
    assign w_rgs_vld   = i_rgs_fifo_vld;
    assign w_rgs_front = i_rgs_fifo_front;
`else
    // Regression inputs are parked; mode is forced to classification.
    assign c_RGS_EN    = 1'b0;
    assign w_is_clf    = 1'b1;
    assign w_rgs_start = 1'b0;
    assign w_rgs_vld   = 1'b0;
    assign w_rgs_front = '0;
    wire w_unused_rgs = ^{i_is_clf, i_rgs_fifo_front, i_rgs_fifo_vld, i_rgs_fifo_is_empty};
`endif

    generate
        for (genvar k = 0; k < N_LABELS; k++) begin : g_lane
            assign w_front[k] = i_clf_fifo_front[k*FIFO_WIDTH +: FIFO_WIDTH];
        end
    endgenerate

    assign w_mask_next = r_mask | i_clf_fifo_vld;
    assign w_clf_done  = &w_mask_next;
    // Lane 0 may be landing in the same cycle the mask completes.
    assign w_lane0     = r_mask[0] ? r_lane[0] : w_front[0];

    always_ff @(posedge clk) begin
        if (rst) r_state <= c_S_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (w_is_clf ? (i_clf_fifo_is_empty == '0) : w_rgs_start)
                    w_next_state = c_S_POP;
            end
            c_S_POP: w_next_state = c_S_CAPTURE;
            c_S_CAPTURE: begin
                if (r_mode) begin
                    if (w_clf_done)
                        w_next_state = (N_LABELS == 1) ? c_S_OUT : c_S_SCAN;
                end else if (w_rgs_vld) begin
                    w_next_state = c_S_OUT;
                end
            end
            c_S_SCAN: begin
                if (r_idx == c_LAST_LANE) w_next_state = c_S_OUT;
            end
            c_S_OUT: begin
                if (res_if.res_rdy) w_next_state = c_S_IDLE;
            end
            default: w_next_state = c_S_IDLE;
        endcase
        if (i_flush) w_next_state = c_S_IDLE;
    end

    always_comb begin
        o_clf_fifo_pop    = '0;
        o_rgs_fifo_pop    = 1'b0;
        o_busy            = (r_state != c_S_IDLE);
        res_if.res_vld    = 1'b0;
        res_if.res_is_clf = 1'b0;
        res_if.res_label  = '0;
        res_if.res_value  = '0;
        res_if.res_tie    = 1'b0;
        case (r_state)
            c_S_POP: begin
                if (r_mode) o_clf_fifo_pop = '1;
                else        o_rgs_fifo_pop = c_RGS_EN;
            end
            c_S_OUT: begin
                res_if.res_vld    = 1'b1;
                res_if.res_is_clf = r_mode;
                res_if.res_label  = r_label;
                res_if.res_value  = r_best;
                res_if.res_tie    = r_tie;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode  <= 1'b0;
            r_mask  <= '0;
            for (int k = 0; k < N_LABELS; k++) r_lane[k] <= '0;
            r_best  <= '0;
            r_label <= '0;
            r_idx   <= '0;
            r_tie   <= 1'b0;
        end else begin
            case (r_state)
                c_S_IDLE: r_mode <= w_is_clf;
                c_S_POP:  r_mask <= '0;
                c_S_CAPTURE: begin
                    if (r_mode) begin
                        for (int k = 0; k < N_LABELS; k++) begin
                            if (i_clf_fifo_vld[k] && !r_mask[k]) begin
                                r_mask[k] <= 1'b1;
                                r_lane[k] <= w_front[k];
                            end
                        end
                        if (w_clf_done) begin
                            r_best  <= w_lane0;
                            r_label <= '0;
                            r_tie   <= 1'b0;
                            r_idx   <= LABEL_W'(1);
                        end
                    end else if (w_rgs_vld) begin
                        r_best  <= w_rgs_front;
                        r_label <= '0;
                        r_tie   <= 1'b0;
                    end
                end
                c_S_SCAN: begin
                    // Strictly-greater replaces; equal only flags, so the lowest index wins.
                    if (r_lane[r_idx] > r_best) begin
                        r_best  <= r_lane[r_idx];
                        r_label <= r_idx;
                        r_tie   <= 1'b0;
                    end else if (r_lane[r_idx] == r_best) begin
                        r_tie   <= 1'b1;
                    end
                    r_idx <= r_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_vote_resolver.sv
`default_nettype none
// ============================================================================
// Module : tb_vote_resolver
// Brief  : Self-checking bench for vote_resolver with a behavioural argmax model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_vote_resolver;
    localparam int W  = 16;
    localparam int N  = 4;
    localparam int LW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            is_clf;
    logic            flush;
    logic [N-1:0]    clf_pop;
    logic [N*W-1:0]  clf_front;
    logic [N-1:0]    clf_vld;
    logic [N-1:0]    clf_empty;
    logic            rgs_pop;
    logic [W-1:0]    rgs_front;
    logic            rgs_vld;
    logic            rgs_empty;
    logic            busy;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    vote_resolver_if #(.FIFO_WIDTH(W), .LABEL_W(LW)) res_if ();

    vote_resolver #(.FIFO_WIDTH(W), .N_LABELS(N)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .i_is_clf            (is_clf),
        .i_flush             (flush),
        .o_clf_fifo_pop      (clf_pop),
        .i_clf_fifo_front    (clf_front),
        .i_clf_fifo_vld      (clf_vld),
        .i_clf_fifo_is_empty (clf_empty),
        .o_rgs_fifo_pop      (rgs_pop),
        .i_rgs_fifo_front    (rgs_front),
        .i_rgs_fifo_vld      (rgs_vld),
        .i_rgs_fifo_is_empty (rgs_empty),
        .res_if              (res_if),
        .o_busy              (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] rnd_cnt();
        if ($urandom_range(0, 3) == 0) return W'($urandom);
        return W'($urandom_range(0, 7));
    endfunction

    // Front words are only meaningful while vld is high; otherwise drive junk.
    task automatic drive_lanes(input logic [N-1:0] v, input logic [N*W-1:0] cnts);
        clf_vld = v;
        for (int k = 0; k < N; k++)
            clf_front[k*W +: W] = v[k] ? cnts[k*W +: W] : W'($urandom);
    endtask

    task automatic check_out(input string tag, input int lbl, input logic [W-1:0] val,
                             input logic tie, input logic is_c);
        chk({tag, ".vld"},   32'(res_if.res_vld), 32'd1);
        chk({tag, ".label"}, 32'(res_if.res_label), 32'(lbl));
        chk({tag, ".value"}, 32'(res_if.res_value), 32'(val));
        chk({tag, ".tie"},   32'(res_if.res_tie), 32'(tie));
        chk({tag, ".isclf"}, 32'(res_if.res_is_clf), 32'(is_c));
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, ".busy"},  32'(busy), 32'd0);
        chk({tag, ".vld"},   32'(res_if.res_vld), 32'd0);
        chk({tag, ".value"}, 32'(res_if.res_value), 32'd0);
        chk({tag, ".label"}, 32'(res_if.res_label), 32'd0);
        chk({tag, ".tie"},   32'(res_if.res_tie), 32'd0);
        chk({tag, ".isclf"}, 32'(res_if.res_is_clf), 32'd0);
        chk({tag, ".cpop"},  32'(clf_pop), 32'd0);
        chk({tag, ".rpop"},  32'(rgs_pop), 32'd0);
    endtask

    // One classification transaction; must be called with the DUT in IDLE.
    // dlys nibble k = cycles after the pop cycle at which lane k returns vld.
    task automatic run_clf(input string tag, input logic [N*W-1:0] cnts,
                           input logic [4*N-1:0] dlys, input int stall);
        logic [W-1:0] mx;
        logic [N-1:0] v;
        int lbl, n_eq, dmax;
        mx = '0;
        for (int k = 0; k < N; k++) if (cnts[k*W +: W] > mx) mx = cnts[k*W +: W];
        lbl = -1; n_eq = 0;
        for (int k = 0; k < N; k++) begin
            if (cnts[k*W +: W] == mx) begin
                if (lbl < 0) lbl = k;
                n_eq++;
            end
        end
        dmax = 0;
        for (int k = 0; k < N; k++) if (int'(dlys[k*4 +: 4]) > dmax) dmax = int'(dlys[k*4 +: 4]);

        res_if.res_rdy = (stall == 0);
        clf_empty = '0;
        step();
        chk({tag, ".pop"},  32'(clf_pop), 32'hF);
        chk({tag, ".busy"}, 32'(busy), 32'd1);
        clf_empty = '1;
        for (int c = 1; c <= dmax + N; c++) begin
            step();
            if (c < dmax + N) begin
                chk({tag, ".early_vld"}, 32'(res_if.res_vld), 32'd0);
                chk({tag, ".one_pop"},   32'(clf_pop), 32'd0);
            end
            for (int k = 0; k < N; k++) v[k] = (int'(dlys[k*4 +: 4]) == c);
            drive_lanes(v, cnts);
        end
        check_out(tag, lbl, mx, (n_eq > 1), 1'b1);
        clf_empty = '0;  // FIFOs refill during OUT; no pop may start before IDLE
        for (int i = 0; i < stall; i++) begin
            step();
            check_out({tag, ".stall"}, lbl, mx, (n_eq > 1), 1'b1);
            chk({tag, ".stall_pop"}, 32'(clf_pop), 32'd0);
        end
        res_if.res_rdy = 1'b1;
        step();
        chk({tag, ".post_vld"},  32'(res_if.res_vld), 32'd0);
        chk({tag, ".post_busy"}, 32'(busy), 32'd0);
        chk({tag, ".post_pop"},  32'(clf_pop), 32'd0);
    endtask

    initial begin
        logic [N*W-1:0] cnts;
        logic [4*N-1:0] dlys;
        rst = 1'b1; is_clf = 1'b1; flush = 1'b0;
        clf_front = '0; clf_vld = '0; clf_empty = '1;
        rgs_front = '0; rgs_vld = 1'b0; rgs_empty = 1'b1;
        res_if.res_rdy = 1'b1;
        step(); step();
        check_idle_outputs("reset");
        rst = 1'b0;
        step();
        chk("reset_release.busy", 32'(busy), 32'd0);

        run_clf("basic",  {16'd5, 16'd2, 16'd7, 16'd3}, 16'h1111, 0);
        run_clf("tie3",   {16'd6, 16'd6, 16'd2, 16'd6}, 16'h1111, 0);
        run_clf("tieclr", {16'd1, 16'd9, 16'd4, 16'd4}, 16'h1111, 0);
        run_clf("skew",   {16'd2, 16'd8, 16'd1, 16'd5}, 16'h1411, 4);

        clf_empty = 4'b1000;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("lane3_empty.pop",  32'(clf_pop), 32'd0);
            chk("lane3_empty.busy", 32'(busy), 32'd0);
        end
        run_clf("lane3_fill", {16'd0, 16'd3, 16'd3, 16'd1}, 16'h2131, 1);

        clf_empty = '1;
        is_clf = 1'b0;
        rgs_empty = 1'b0;
`ifdef VOTE_RESOLVER_RGS_EN
        step();
        chk("rgs.pop",  32'(rgs_pop), 32'd1);
        chk("rgs.cpop", 32'(clf_pop), 32'd0);
        rgs_empty = 1'b1;
        is_clf = 1'b1;
        step();
        chk("rgs.one_pop", 32'(rgs_pop), 32'd0);
        rgs_vld = 1'b1; rgs_front = 16'h1234;
        step();
        rgs_vld = 1'b0; rgs_front = 16'hBEEF;
        check_out("rgs", 0, 16'h1234, 1'b0, 1'b0);
        step();
        chk("rgs.post_vld",  32'(res_if.res_vld), 32'd0);
        chk("rgs.post_busy", 32'(busy), 32'd0);
`else
        rgs_front = 16'h1234;
        for (int i = 0; i < 3; i++) begin
            rgs_vld = (i == 1);
            step();
            chk("rgs_off.pop",  32'(rgs_pop), 32'd0);
            chk("rgs_off.cpop", 32'(clf_pop), 32'd0);
            chk("rgs_off.busy", 32'(busy), 32'd0);
        end
        rgs_vld = 1'b0;
`endif
        is_clf = 1'b1;
        rgs_empty = 1'b1;

        cnts = {16'd4, 16'd3, 16'd2, 16'd1};
        clf_empty = '0;
        step();
        chk("flush.pop", 32'(clf_pop), 32'hF);
        clf_empty = '1;
        step();
        drive_lanes('1, cnts);
        step();
        drive_lanes('0, cnts);
        chk("flush.scan_busy", 32'(busy), 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_idle_outputs("flush");
        step();
        chk("flush.stay_idle", 32'(busy), 32'd0);

        clf_empty = '0;
        step();
        chk("rst_mid.pop", 32'(clf_pop), 32'hF);
        clf_empty = '1;
        step();
        rst = 1'b1;
        drive_lanes(4'b0011, cnts);
        step();
        rst = 1'b0;
        drive_lanes('0, cnts);
        check_idle_outputs("rst_mid");
        step();
        chk("rst_mid.stay_idle", 32'(busy), 32'd0);
        run_clf("after_rst", {16'd7, 16'd7, 16'd0, 16'd2}, 16'h3121, 2);

        for (int t = 0; t < 8; t++) begin
            for (int k = 0; k < N; k++) begin
                cnts[k*W +: W] = rnd_cnt();
                dlys[k*4 +: 4] = 4'($urandom_range(1, 4));
            end
            run_clf("rand", cnts, dlys, int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
